// File: rtl/multiplier_32bit_seq.sv
// Iterative shift-and-add multiplier for the RV32M multiply group.
// Fixed 33-cycle latency: 32 add/shift cycles followed by one sign-correction cycle.
module multiplier_32bit_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mul_start,
  input  logic [1:0]  mul_opcode,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic        mul_flush,
  output logic        mul_busy,
  output logic        mul_valid,
  output logic [31:0] result_multiply
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [63:0] acc;
  logic [4:0]  cnt;
  logic        neg;
  logic        sign_a, sign_b;
  logic [63:0] prod_fin;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude
  function automatic logic [31:0] mag(input logic signed [31:0] v, input logic is_neg);
    logic signed [31:0] n;
    n = -v;
    return is_neg ? n : v;
  endfunction

  function automatic logic [63:0] apply_sign(input logic [63:0] v, input logic n);
    return n ? (~v + 64'd1) : v;
  endfunction

  assign sign_a   = operand1[31] & ((mul_opcode == OP_MULH) | (mul_opcode == OP_MULHSU));
  assign sign_b   = operand2[31] & (mul_opcode == OP_MULH);
  assign prod_fin = apply_sign(acc, neg);
  assign mul_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mul_start) state_nxt = CALC;
      CALC:    if (cnt == 5'd31) state_nxt = SIGN;
      SIGN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (mul_flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q            <= OP_MUL;
      mcand           <= '0;
      mplier          <= '0;
      acc             <= '0;
      cnt             <= '0;
      neg             <= 1'b0;
      mul_valid       <= 1'b0;
      result_multiply <= '0;
    end else begin
      mul_valid <= 1'b0;
      if (!mul_flush) begin
        case (state)
          IDLE: if (mul_start) begin
            op_q   <= mul_opcode;
            mcand  <= {32'd0, mag(operand1, sign_a)};
            mplier <= mag(operand2, sign_b);
            neg    <= sign_a ^ sign_b;
            acc    <= '0;
            cnt    <= '0;
          end
          CALC: begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
          end
          SIGN: begin
            result_multiply <= (op_q == OP_MUL) ? prod_fin[31:0] : prod_fin[63:32];
            mul_valid       <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
